// File: rtl/multicycle_control_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS controller.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds the HALT state).
package mc_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } mc_state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0111;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ADDI,
    CLS_ORI,
    CLS_J
  } mc_class_e;

  // Registered Moore strobes; ir_write and the fetch-time pc_write are
  // derived from mem_ready separately.
  typedef struct packed {
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
  } mc_ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath <-> controller bundle. master = controller, slave = datapath.
// Handshake: the controller holds mem_read/mem_write steady until a cycle in
// which mem_ready is 1; that cycle completes the access (no minimum wait).
interface multicycle_control_if;

  logic [5:0]                   opcode;
  logic [5:0]                   funct;
  logic                         zero;
  logic                         mem_ready;
  logic                         mem_read;
  logic                         mem_write;
  logic                         iord;
  logic                         ir_write;
  logic                         pc_write;
  logic                         pc_write_cond;
  logic [1:0]                   pc_src;
  logic                         alu_src_a;
  logic [1:0]                   alu_src_b;
  logic [mc_pkg::ALU_OP_W-1:0]  alu_op;
  logic                         reg_write;
  logic                         reg_dst;
  logic                         mem_to_reg;
  logic                         illegal;
  mc_pkg::mc_state_e            dbg_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, illegal, dbg_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, illegal, dbg_state
  );

endinterface

// File: rtl/multicycle_control_decode.sv
// mc_decode: opcode/funct -> instruction class, EXEC-cycle ALU op and a
// supported flag. Purely combinational.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output mc_class_e           cls,
  output logic [ALU_OP_W-1:0] exec_alu_op,
  output logic                supported
);

  // Classify the instruction; unknown opcode or R-type funct maps to CLS_NONE
  always_comb begin
    cls         = CLS_NONE;
    exec_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (funct)
          FN_ADD:  exec_alu_op = ALU_ADD;
          FN_SUB:  exec_alu_op = ALU_SUB;
          FN_AND:  exec_alu_op = ALU_AND;
          FN_OR:   exec_alu_op = ALU_OR;
          FN_SLL:  exec_alu_op = ALU_SLL;
          FN_SRL:  exec_alu_op = ALU_SRL;
          FN_SLTU: exec_alu_op = ALU_SLTU;
          default: cls = CLS_NONE;
        endcase
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_ADDI: cls = CLS_ADDI;
      OP_ORI: begin
        cls         = CLS_ORI;
        exec_alu_op = ALU_OR;
      end
      OP_BEQ: begin
        cls         = CLS_BEQ;
        exec_alu_op = ALU_SUB;
      end
      OP_J:    cls = CLS_J;
      default: cls = CLS_NONE;
    endcase
    supported = (cls != CLS_NONE);
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle
// MIPS datapath with a shared, stallable memory port.
// Optional feature macro: MC_ILLEGAL_TRAP_EN -- unsupported instructions park
// the controller in HALT with illegal=1 until reset; otherwise they are NOPs.
module multicycle_control
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus
);

  mc_state_e           state_q, state_d;
  mc_ctl_t             ctl_q, ctl_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;
  mc_class_e           cls;
  logic [ALU_OP_W-1:0] exec_alu_op;
  logic                supported;
  logic                fetch_done;
  logic                mem_done;

  // IR fields are live in DECODE and captured there; later states use the copy
  always_comb begin
    opcode_d = opcode_q;
    funct_d  = funct_q;
    if (state_q == S_DECODE) begin
      opcode_d = bus.opcode;
      funct_d  = bus.funct;
    end
  end

  mc_decode u_decode (
    .opcode      (opcode_d),
    .funct       (funct_d),
    .cls         (cls),
    .exec_alu_op (exec_alu_op),
    .supported   (supported)
  );

  // A fetch only completes once the read request is actually on the port,
  // which keeps the idle cycle right after reset free of strobes.
  assign fetch_done = (state_q == S_FETCH) && ctl_q.mem_read && bus.mem_ready;
  assign mem_done   = (state_q == S_MEM) && bus.mem_ready;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: begin
        if (supported) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (cls)
          CLS_LW, CLS_SW:  state_d = S_MEM;
          CLS_BEQ, CLS_J:  state_d = S_FETCH;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_done) state_d = (cls == CLS_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore strobes for the state being entered, registered alongside it
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.mem_read  = 1'b1;
        ctl_d.alu_src_b = 2'b01;
        ctl_d.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctl_d.alu_src_b = 2'b11;
        ctl_d.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        case (cls)
          CLS_RTYPE: begin
            ctl_d.alu_src_a = 1'b1;
            ctl_d.alu_src_b = 2'b00;
            ctl_d.alu_op    = exec_alu_op;
          end
          CLS_LW, CLS_SW, CLS_ADDI, CLS_ORI: begin
            ctl_d.alu_src_a = 1'b1;
            ctl_d.alu_src_b = 2'b10;
            ctl_d.alu_op    = exec_alu_op;
          end
          CLS_BEQ: begin
            ctl_d.alu_src_a     = 1'b1;
            ctl_d.alu_src_b     = 2'b00;
            ctl_d.alu_op        = exec_alu_op;
            ctl_d.pc_write_cond = 1'b1;
            ctl_d.pc_src        = 2'b01;
          end
          CLS_J: begin
            ctl_d.pc_write = 1'b1;
            ctl_d.pc_src   = 2'b10;
          end
          default: ctl_d = '0;
        endcase
      end
      S_MEM: begin
        ctl_d.iord      = 1'b1;
        ctl_d.mem_read  = (cls == CLS_LW);
        ctl_d.mem_write = (cls == CLS_SW);
      end
      S_WB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.reg_dst    = (cls == CLS_RTYPE);
        ctl_d.mem_to_reg = (cls == CLS_LW);
      end
      default: ctl_d = '0;
    endcase
  end

  // Single state register with registered strobes and latched IR fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ctl_q    <= '0;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  // ir_write and the PC increment fire in the same cycle the fetch completes
  assign bus.ir_write      = fetch_done;
  assign bus.pc_write      = ctl_q.pc_write | fetch_done;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.iord          = ctl_q.iord;
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.pc_src        = ctl_q.pc_src;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.dbg_state     = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal       = (state_q == S_HALT);
`else
  assign bus.illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction sequence followed by
// random instructions with random memory stalls, every cycle compared
// against a per-instruction cycle-list model built from the opcode rules.
module tb_multicycle_control;

  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000,
                         A_OR = 4'b0001, A_SLL = 4'b1010, A_SRL = 4'b1100,
                         A_SLTU = 4'b0111;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_ADDI = 6'b001000,
                         O_ORI = 6'b001101, O_J = 6'b000010, O_BAD = 6'b111111;

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_ORI, K_J, K_BAD} kind_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } obs_t;

  localparam int W = $bits(obs_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] care_q[$];
  logic         rdy_q[$];
  logic [5:0]   op_q[$];
  logic [5:0]   fn_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  int           zero_mode = 2;  // 0/1 drive that value, 2 random

  logic [5:0] r_fn [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b000000, 6'b000010, 6'b101011};

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b000000: return A_SLL;
      6'b000010: return A_SRL;
      default:   return A_SLTU;
    endcase
  endfunction

  function automatic bit r_ok(input logic [5:0] fn);
    foreach (r_fn[i]) if (r_fn[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic kind_e kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      O_R:     return r_ok(fn) ? K_R : K_BAD;
      O_LW:    return K_LW;
      O_SW:    return K_SW;
      O_BEQ:   return K_BEQ;
      O_ADDI:  return K_ADDI;
      O_ORI:   return K_ORI;
      O_J:     return K_J;
      default: return K_BAD;
    endcase
  endfunction

  // Write/request strobes must be exactly right in every cycle
  function automatic obs_t strobe_care();
    obs_t c;
    c = '0;
    c.mem_read = 1'b1; c.mem_write = 1'b1; c.ir_write = 1'b1;
    c.pc_write = 1'b1; c.pc_write_cond = 1'b1; c.reg_write = 1'b1;
    c.illegal = 1'b1;
    return c;
  endfunction

  function automatic logic [W-1:0] sample_outs();
    obs_t o;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.iord          = bus.iord;
    o.ir_write      = bus.ir_write;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_src        = bus.pc_src;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.reg_write     = bus.reg_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.illegal       = bus.illegal;
    return o;
  endfunction

  task automatic check_outs(input logic [W-1:0] e, input logic [W-1:0] c, input string tag);
    logic [W-1:0] o;
    o = sample_outs();
    checks++;
    assert ((o & c) === (e & c)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (care %h)", tag, o & c, e & c, c);
    end
  endtask

  task automatic check_zero(input string tag);
    check_outs('0, '1, tag);
  endtask

  task automatic push_cycle(input obs_t e, input obs_t c, input logic rdy,
                            input logic [5:0] op, input logic [5:0] fn, input string tag);
    exp_q.push_back(e);
    care_q.push_back(c);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
    fn_q.push_back(fn);
    tag_q.push_back(tag);
  endtask

  task automatic drop_tail(input int n);
    for (int i = 0; i < n; i++) begin
      void'(exp_q.pop_back()); void'(care_q.pop_back()); void'(rdy_q.pop_back());
      void'(op_q.pop_back()); void'(fn_q.pop_back()); void'(tag_q.pop_back());
    end
  endtask

  // ---------------- reference model: one instruction -> list of cycles ----
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fstall, input int mstall);
    obs_t  e, c;
    kind_e k;
    k = kind_of(op, fn);
    for (int i = 0; i <= fstall; i++) begin
      e = '0; c = strobe_care();
      e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = A_ADD;
      c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 4'hf;
      if (i == fstall) begin
        e.ir_write = 1'b1; e.pc_write = 1'b1; c.pc_src = 2'b11;
      end
      push_cycle(e, c, (i == fstall), 6'($urandom), 6'($urandom), "fetch");
    end
    e = '0; c = strobe_care();
    e.alu_src_b = 2'b11; e.alu_op = A_ADD;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 4'hf;
    push_cycle(e, c, 1'($urandom), op, fn, "decode");
    if (k == K_BAD) begin
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        e = '0; e.illegal = 1'b1; c = '1;
        push_cycle(e, c, 1'($urandom), op, fn, "halt");
      end
`endif
      return;
    end
    e = '0; c = strobe_care();
    case (k)
      K_R: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = r_alu(fn);
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 4'hf;
      end
      K_LW, K_SW, K_ADDI: begin
        e.alu_src_b = 2'b10; e.alu_op = A_ADD;
        c.alu_src_b = 2'b11; c.alu_op = 4'hf;
      end
      K_ORI: begin
        e.alu_src_b = 2'b10; e.alu_op = A_OR;
        c.alu_src_b = 2'b11; c.alu_op = 4'hf;
      end
      K_BEQ: begin
        e.alu_src_b = 2'b00; e.alu_op = A_SUB; e.pc_write_cond = 1'b1; e.pc_src = 2'b01;
        c.alu_src_b = 2'b11; c.alu_op = 4'hf; c.pc_src = 2'b11;
      end
      K_J: begin
        e.pc_write = 1'b1; e.pc_src = 2'b10; c.pc_src = 2'b11;
      end
      default: ;
    endcase
    push_cycle(e, c, 1'($urandom), op, fn, "exec");
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mstall; i++) begin
        e = '0; c = strobe_care();
        e.iord = 1'b1; c.iord = 1'b1;
        e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
        push_cycle(e, c, (i == mstall), op, fn, "mem");
      end
    end
    if (k inside {K_R, K_LW, K_ADDI, K_ORI}) begin
      e = '0; c = strobe_care();
      e.reg_write = 1'b1; e.reg_dst = (k == K_R); e.mem_to_reg = (k == K_LW);
      c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
      push_cycle(e, c, 1'($urandom), op, fn, "wb");
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_queue();
    logic [W-1:0] e, c;
    string        tag;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      bus.mem_ready = rdy_q.pop_front();
      bus.opcode    = op_q.pop_front();
      bus.funct     = fn_q.pop_front();
      bus.zero      = (zero_mode == 2) ? 1'($urandom) : zero_mode[0];
      e   = exp_q.pop_front();
      c   = care_q.pop_front();
      tag = tag_q.pop_front();
      @(negedge clk);
      check_outs(e, c, tag);
    end
  endtask

  // Called just after a negedge check; releases on a later negedge
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1 bus.mem_ready = 1'b1;
    check_zero({tag, "_async"});
    @(posedge clk);
    #1 check_zero({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero({tag, "_release"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    kind_e      k;
    logic [5:0] op, fn;
    bus.mem_ready = 1'b1;
    bus.opcode    = O_LW;
    bus.funct     = '0;
    bus.zero      = 1'b0;

    // Reset: everything low even with mem_ready high
    #3 check_zero("reset_async");
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero("reset_release");

    // add, zero-wait: 4 cycles
    model_instr(O_R, 6'b100000, 0, 0);
    run_queue();

    // lw, 2 fetch stalls + 3 mem stalls: 10 cycles
    model_instr(O_LW, 6'($urandom), 2, 3);
    run_queue();

    // beq with zero forced 1 then 0
    zero_mode = 1;
    model_instr(O_BEQ, 6'($urandom), 0, 0);
    run_queue();
    zero_mode = 0;
    model_instr(O_BEQ, 6'($urandom), 0, 0);
    run_queue();
    zero_mode = 2;

    // sw then j
    model_instr(O_SW, 6'($urandom), 0, 1);
    model_instr(O_J, 6'($urandom), 0, 0);
    run_queue();

    // Remaining R-type functs and immediates
    for (int i = 1; i < 7; i++) model_instr(O_R, r_fn[i], $urandom_range(0, 2), 0);
    model_instr(O_ADDI, 6'($urandom), 1, 0);
    model_instr(O_ORI, 6'($urandom), 0, 0);
    run_queue();

    // Reset during a stalled sw MEM cycle: stop after the first MEM cycle
    model_instr(O_SW, 6'($urandom), 0, 3);
    drop_tail(3);
    run_queue();
    reset_pulse("sw_mem_reset");
    model_instr(O_R, 6'b100010, 0, 0);
    run_queue();

    // Unsupported opcode and unsupported R-type funct
`ifdef MC_ILLEGAL_TRAP_EN
    model_instr(O_BAD, 6'($urandom), 0, 0);
    run_queue();
    reset_pulse("halt_reset");
`else
    model_instr(O_BAD, 6'($urandom), 0, 0);
    model_instr(O_R, 6'b000001, 1, 0);
    model_instr(O_R, 6'b100000, 0, 0);
    run_queue();
`endif

    // Random instruction stream with random stalls
    for (int n = 0; n < 40; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      k = kind_e'($urandom_range(0, 6));
`else
      k = kind_e'($urandom_range(0, 7));
`endif
      fn = 6'($urandom);
      case (k)
        K_R:     begin op = O_R; fn = r_fn[$urandom_range(0, 6)]; end
        K_LW:    op = O_LW;
        K_SW:    op = O_SW;
        K_BEQ:   op = O_BEQ;
        K_ADDI:  op = O_ADDI;
        K_ORI:   op = O_ORI;
        K_J:     op = O_J;
        default: begin
          if ($urandom_range(0, 1) == 0) op = O_BAD;
          else begin op = O_R; fn = 6'b111110; end
        end
      endcase
      model_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
      run_queue();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath: fetches each instruction over a shared instruction/data memory port, decodes opcode/funct, and steps the datapath through FETCH, DECODE, EXEC, MEM and WB one state per cycle. Drives every datapath strobe: PC/IR write enables, mux selects, register-file write, memory request and ALU operation. Sits beside the datapath, replacing the single-cycle combinational decoder when memory is shared and may stall.

## Interface
- ALU_OP_W, 4, width of alu_op; fixed ALU encoding below.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in EXEC for beq.
- mem_ready  in  1  memory completes the current read or write this cycle.
- mem_read / mem_write  out  1  memory request; held until mem_ready.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR; pulses with fetch mem_ready.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if zero (beq).
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_op  out  ALU_OP_W  0010 add, 0110 sub, 0000 and, 0001 or, 1010 sll, 1100 srl, 0111 sltu.
- reg_write / reg_dst / mem_to_reg  out  1  register-file write, dest = rd when 1, write data = MDR when 1.
- illegal  out  1  unsupported instruction (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Registered state; outputs are Moore decodes of state plus latched opcode/funct.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add. Stays in FETCH while mem_ready=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Next EXEC; j goes directly to EXEC.
- EXEC by class:
  - R-type (add, sub, and, or, sll, srl, sltu): alu_src_a=1, alu_src_b=00, funct-selected alu_op; next WB.
  - lw/sw/addi: alu_src_b=10, add; lw/sw next MEM, addi next WB.
  - ori: alu_src_b=10, or; next WB.
  - beq: alu_src_b=00, sub, pc_write_cond=1, pc_src=01; next FETCH.
  - j: pc_write=1, pc_src=10; next FETCH.
- MEM: iord=1; lw asserts mem_read, sw asserts mem_write; wait for mem_ready. sw next FETCH, lw next WB.
- WB: reg_write=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only. Next FETCH.
- Unsupported opcode or R-type funct: behaviour per Configuration; never writes registers or memory.

## Timing
- Reset (async assert): state=FETCH, every output 0, including illegal. Outputs stay 0 while rst_n=0. FETCH strobes begin in the first cycle after deassertion.
- Cycles per instruction with zero-wait memory: beq 3, j 3, R-type 4, addi/ori 4, sw 4, lw 5. Each cycle mem_ready is low adds one cycle to FETCH or MEM.
- mem_ready in the same cycle the request first asserts completes the access; no minimum wait. mem_ready outside FETCH/MEM is ignored.
- Reset mid-instruction aborts immediately with no partial write; PC/IR contents belong to the datapath.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: unsupported instruction in DECODE goes to HALT. HALT holds illegal=1 and all other outputs 0 until rst_n.
- Undefined: unsupported instruction is a NOP (DECODE to FETCH, illegal tied 0). HALT is not built.

## Structure
- Package mc_pkg: state enum, opcode constants (000000, 100011, 101011, 000100, 001000, 001101, 000010), funct constants, alu_op codes.
- Sub-module mc_decode: combinational opcode/funct to instruction class, EXEC alu_op and supported flag. The FSM lives in multicycle_control.

## Test plan
- Reset release, mem_ready tied 1, IR = add: FETCH, DECODE, EXEC (alu_op 0010, src_b 00), WB (reg_write=1, reg_dst=1); 4 cycles.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM: 10 cycles total; mem_read held constant during stalls; WB has mem_to_reg=1.
- beq with zero=1, then zero=0: EXEC asserts pc_write_cond=1, pc_src=01, alu_op 0110; back in FETCH at cycle 3 in both cases.
- sw then j: sw EXEC then MEM with mem_write=1, iord=1, reg_write never 1; j EXEC pc_write=1, pc_src=10, 3 cycles.
- rst_n pulsed low mid-MEM of sw: mem_write drops to 0 asynchronously; FETCH starts cycle after release.
- opcode 111111: with MC_ILLEGAL_TRAP_EN, HALT and illegal=1 held until reset; without it, return to FETCH after DECODE with no writes.
